// File: rtl/alu_iter.sv
// Parametrised-width ALU with valid/ready handshakes on both sides, registered results,
// and an iterative shift-add multiplier.
module alu_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             carry,
   output logic             less,
   output logic             err
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_NOT  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_EQ   = 4'd7;
   localparam logic [3:0] OP_SLTU = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept_c;
   logic             mul_last_c;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc_step_c;

   logic [WIDTH:0]   sum_c;
   logic [WIDTH:0]   dif_c;
   logic             add_ovf_c;
   logic             sub_ovf_c;
   logic [WIDTH-1:0] alu_res_c;
   logic             alu_ovf_c;
   logic             alu_cry_c;
   logic             alu_less_c;
   logic             alu_err_c;

   // Single-cycle datapath; subtraction is a + ~b + 1 so carry-out means "no borrow"
   assign sum_c     = {1'b0, a} + {1'b0, b};
   assign dif_c     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   assign add_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) & (sum_c[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) & (dif_c[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      alu_res_c  = '0;
      alu_ovf_c  = 1'b0;
      alu_cry_c  = 1'b0;
      alu_less_c = 1'b0;
      alu_err_c  = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res_c = sum_c[WIDTH-1:0];
            alu_cry_c = sum_c[WIDTH];
            alu_ovf_c = add_ovf_c;
         end
         OP_SUB: begin
            alu_res_c = dif_c[WIDTH-1:0];
            alu_cry_c = dif_c[WIDTH];
            alu_ovf_c = sub_ovf_c;
         end
         OP_NOT: alu_res_c = ~a;
         OP_AND: alu_res_c = a & b;
         OP_OR:  alu_res_c = a | b;
         OP_XOR: alu_res_c = a ^ b;
         OP_SLT: begin
            alu_less_c = dif_c[WIDTH-1] ^ sub_ovf_c;
            alu_res_c  = WIDTH'(alu_less_c);
         end
         OP_EQ:  alu_res_c = WIDTH'(a == b);
         OP_SLTU: begin
            alu_less_c = ~dif_c[WIDTH];
            alu_res_c  = WIDTH'(alu_less_c);
         end
         OP_MUL: alu_res_c = '0;
         default: alu_err_c = 1'b1;
      endcase
   end

   assign accept_c   = in_valid & in_ready;
   assign acc_step_c = acc + (mplier[0] ? mcand : '0);
   assign mul_last_c = (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = (op == OP_MUL) ? MUL : DONE;
         MUL:  if (mul_last_c) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Result/flag registers and the shift-add multiplier state
   always_ff @(posedge clk) begin
      if (rst) begin
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         carry    <= 1'b0;
         less     <= 1'b0;
         err      <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
      end else if (accept_c) begin
         if (op == OP_MUL) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
         end else begin
            result   <= alu_res_c;
            zero     <= (alu_res_c == '0);
            overflow <= alu_ovf_c;
            carry    <= alu_cry_c;
            less     <= alu_less_c;
            err      <= alu_err_c;
         end
      end else if (state == MUL) begin
         acc    <= acc_step_c;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CNT_W'(1);
         if (mul_last_c) begin
            result   <= acc_step_c;
            zero     <= (acc_step_c == '0);
            overflow <= 1'b0;
            carry    <= 1'b0;
            less     <= 1'b0;
            err      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: an 8-bit instance for most vectors and a 32-bit
// instance for the wide multiply latency/result.
module tb_alu_iter;

   logic       clk = 1'b0;
   logic       rst;

   logic       in_valid, in_ready, out_valid, out_ready;
   logic [3:0] op;
   logic [7:0] a, b, result;
   logic       zero, overflow, carry, less, err;

   logic        in_valid32, in_ready32, out_valid32, out_ready32;
   logic [3:0]  op32;
   logic [31:0] a32, b32, result32;
   logic        zero32, overflow32, carry32, less32, err32;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_iter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .overflow(overflow), .carry(carry), .less(less), .err(err)
   );

   alu_iter #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .op(op32),
      .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32), .result(result32),
      .zero(zero32), .overflow(overflow32), .carry(carry32), .less(less32), .err(err32)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // flags packed as {zero, overflow, carry, less, err}
   function automatic logic [31:0] flags8();
      return 32'({zero, overflow, carry, less, err});
   endfunction

   // Present a bundle at a negedge and retire it after the accepting posedge
   task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      chk("issue_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1 in_valid = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00;
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("handoff_out_valid", 32'(out_valid), 32'd0);
      chk("handoff_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic do_op(input string tag, input logic [3:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] er, input logic [4:0] ef);
      issue(o, x, y);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_result"}, 32'(result), 32'(er));
      chk({tag, "_flags"}, flags8(), 32'(ef));
      handoff();
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00;
      in_valid32 = 1'b0; out_ready32 = 1'b0; op32 = 4'h0; a32 = '0; b32 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_flags", flags8(), 32'd0);
      chk("rst32_in_ready", 32'(in_ready32), 32'd1);
      chk("rst32_out_valid", 32'(out_valid32), 32'd0);

      do_op("add_ovf",   4'd0, 8'h7F, 8'h01, 8'h80, 5'b01000);
      do_op("add_carry", 4'd0, 8'hFF, 8'h01, 8'h00, 5'b10100);
      do_op("sub_borrow",4'd1, 8'h00, 8'h01, 8'hFF, 5'b00000);
      do_op("slt",       4'd6, 8'h80, 8'h01, 8'h01, 5'b00010);
      do_op("sltu",      4'd8, 8'h80, 8'h01, 8'h00, 5'b10000);
      do_op("eq",        4'd7, 8'h5A, 8'h5A, 8'h01, 5'b00000);
      do_op("not",       4'd2, 8'h00, 8'h33, 8'hFF, 5'b00000);
      do_op("or",        4'd4, 8'hA0, 8'h05, 8'hA5, 5'b00000);
      do_op("xor",       4'd5, 8'hAA, 8'hFF, 8'h55, 5'b00000);

      // 8-bit multiply: busy T+1..T+8, result in T+9
      issue(4'd9, 8'h0F, 8'h11);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk("mul8_busy_valid", 32'(out_valid), 32'd0);
         chk("mul8_busy_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      chk("mul8_valid", 32'(out_valid), 32'd1);
      chk("mul8_ready", 32'(in_ready), 32'd0);
      chk("mul8_result", 32'(result), 32'h0000_00FF);
      chk("mul8_flags", flags8(), 32'd0);
      handoff();

      // 32-bit multiply: result in T+33
      @(negedge clk);
      in_valid32 = 1'b1; op32 = 4'd9; a32 = 32'hFFFF_FFFF; b32 = 32'd2;
      @(posedge clk);
      #1 in_valid32 = 1'b0;
      repeat (32) @(negedge clk);
      chk("mul32_busy_valid", 32'(out_valid32), 32'd0);
      @(negedge clk);
      chk("mul32_valid", 32'(out_valid32), 32'd1);
      chk("mul32_result", result32, 32'hFFFF_FFFE);
      chk("mul32_flags", 32'({zero32, overflow32, carry32, less32, err32}), 32'd0);
      out_ready32 = 1'b1;
      @(posedge clk);
      #1 out_ready32 = 1'b0;
      @(negedge clk);
      chk("mul32_handoff", 32'(out_valid32), 32'd0);

      // Backpressure with a pending ADD offered while busy
      issue(4'd0, 8'h7F, 8'h01);
      @(negedge clk);
      in_valid = 1'b1; op = 4'd0; a = 8'h10; b = 8'h20;
      for (int i = 0; i < 6; i++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_result", 32'(result), 32'h80);
         chk("bp_flags", flags8(), 32'(5'b01000));
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("bp_idle_valid", 32'(out_valid), 32'd0);
      chk("bp_idle_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp_pend_valid", 32'(out_valid), 32'd1);
      chk("bp_pend_result", 32'(result), 32'h30);
      handoff();

      // Reset three cycles into a multiply
      issue(4'd9, 8'h0F, 8'h11);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_ready", 32'(in_ready), 32'd1);
      chk("mrst_result", 32'(result), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("mrst_no_deliver", 32'(out_valid), 32'd0);
      end
      do_op("add_post_rst", 4'd0, 8'h02, 8'h03, 8'h05, 5'b00000);

      do_op("illegal", 4'hF, 8'h12, 8'h34, 8'h00, 5'b10001);
      do_op("and_after_illegal", 4'd3, 8'hF0, 8'h3C, 8'h30, 5'b00000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
